regfile_alu_seq: RTL and testbench

Parametrised register-file + ALU datapath, the next generation of the fixed 64-bit/32-register DatapathRegALU. Accepts one packed control word per valid/ready handshake, reads two operands, executes single-cycle ALU/shift ops or an optional multi-cycle shift-add multiply, writes back and latches condition flags. It sits between the control unit (control-word source) and the memory/PC muxing of the CPU datapath.

---
 rtl/regalu_pkg.sv | 39 +++
 rtl/alu_core.sv | 49 ++++
 rtl/regfile_alu_seq.sv | 156 +++++++++++++++
 tb/tb_regfile_alu_seq.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regalu_pkg.sv
// regalu_pkg: opcode encodings, control-word layout and FSM states shared by
// regfile_alu_seq and alu_core.
package regalu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_SHL  = 3'b100;
  localparam logic [2:0] OP_SHR  = 3'b101;
  localparam logic [2:0] OP_MUL  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  // Control word: {DA, SA, SB, FS[4:0], reg_w, sel_k, sl}, DA at the MSB end.
  localparam int FS_W      = 5;
  localparam int SL_BIT    = 0;
  localparam int SEL_K_BIT = 1;
  localparam int REG_W_BIT = 2;
  localparam int FS_LSB    = 3;
  localparam int SB_LSB    = 8;

  function automatic int cw_width(input int aw);
    return 3 * aw + 8;
  endfunction

  function automatic int sa_lsb(input int aw);
    return SB_LSB + aw;
  endfunction

  function automatic int da_lsb(input int aw);
    return SB_LSB + 2 * aw;
  endfunction

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU for regfile_alu_seq. Produces the result and
// {V, C, N, Z}; the MUL opcode yields zero here and is handled by the top.
module alu_core
  import regalu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       fs,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int SHW = $clog2(WIDTH);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             c;
  logic             v;

  assign b_eff = fs[1] ? ~b : b;
  assign sum   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, fs[0]};

  always_comb begin
    // NOTE: every output of this block is defaulted first, so no case arm can infer a latch.
    result = '0;
    c      = 1'b0;
    v      = 1'b0;
    case (fs[4:2])
      OP_AND:  result = a & b_eff;
      OP_OR:   result = a | b_eff;
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        c      = sum[WIDTH];
        v      = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_XOR:  result = a ^ b_eff;
      OP_SHL:  result = a << b_eff[SHW-1:0];
      OP_SHR:  result = a >> b_eff[SHW-1:0];
      OP_MUL:  result = '0;
      OP_PASS: result = b_eff;
      default: result = '0;
    endcase
  end

  assign flags = {v, c, result[WIDTH-1], (result == '0)};

endmodule

// File: rtl/regfile_alu_seq.sv
// regfile_alu_seq: register file + ALU datapath with valid/ready control-word
// intake. Define REGALU_MUL_EN to build the multi-cycle shift-add multiplier.
module regfile_alu_seq
  import regalu_pkg::*;
#(
  parameter  int WIDTH = 64,
  parameter  int NREG  = 32,
  localparam int AW    = $clog2(NREG),
  localparam int CW_W  = cw_width(AW)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cw_valid,
  output logic             cw_ready,
  input  logic [CW_W-1:0]  control_word,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] data,
  output logic [4:0]       status,
  output logic             busy,
  output logic             done
);

  localparam int            DA_LSB   = da_lsb(AW);
  localparam int            SA_LSB   = sa_lsb(AW);
  localparam logic [AW-1:0] ZERO_REG = AW'(NREG - 1);

  logic [AW-1:0]    cw_da;
  logic [AW-1:0]    cw_sa;
  logic [AW-1:0]    cw_sb;
  logic [FS_W-1:0]  cw_fs;
  logic             cw_reg_w;
  logic             cw_sel_k;
  logic             cw_sl;

  logic [WIDTH-1:0] regs [NREG];
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_flags;
  logic [3:0]       flags;
  logic             accept;
  logic             is_mul;
  logic             wr_en;

  assign cw_da    = control_word[DA_LSB +: AW];
  assign cw_sa    = control_word[SA_LSB +: AW];
  assign cw_sb    = control_word[SB_LSB +: AW];
  assign cw_fs    = control_word[FS_LSB +: FS_W];
  assign cw_reg_w = control_word[REG_W_BIT];
  assign cw_sel_k = control_word[SEL_K_BIT];
  assign cw_sl    = control_word[SL_BIT];

  // The top register is hard-wired to zero regardless of its storage.
  assign op_a = (cw_sa == ZERO_REG) ? '0 : regs[cw_sa];
  assign op_b = cw_sel_k ? k : ((cw_sb == ZERO_REG) ? '0 : regs[cw_sb]);

  assign accept = cw_valid && cw_ready;
  assign is_mul = (cw_fs[4:2] == OP_MUL);
  assign wr_en  = cw_reg_w && (cw_da != ZERO_REG);
  assign status = {(data == '0), flags};

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu (
    .a      (op_a),
    .b      (op_b),
    .fs     (cw_fs),
    .result (alu_result),
    .flags  (alu_flags)
  );

`ifdef REGALU_MUL_EN
  localparam int CNT_W = $clog2(WIDTH);

  state_t           state;
  logic [CNT_W-1:0] mul_cnt;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH-1:0] mul_next;
  logic [WIDTH-1:0] mul_b_src;
  logic [AW-1:0]    mul_da;
  logic             mul_reg_w;
  logic             mul_sl;
  logic             mul_last;

  // One multiplier bit per cycle; only the low WIDTH product bits are kept.
  assign mul_b_src = cw_fs[1] ? ~op_b : op_b;
  assign mul_next  = mul_acc + (mul_b[0] ? mul_a : '0);
  assign mul_last  = (mul_cnt == CNT_W'(WIDTH - 1));
  assign cw_ready  = (state == ST_IDLE);
  assign busy      = (state == ST_MUL);
`else
  assign cw_ready = 1'b1;
  assign busy     = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: the register file is cleared by reset because software relies on every register reading 0 afterwards.
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      data  <= '0;
      flags <= '0;
      done  <= 1'b0;
`ifdef REGALU_MUL_EN
      state     <= ST_IDLE;
      mul_cnt   <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      mul_acc   <= '0;
      mul_da    <= '0;
      mul_reg_w <= 1'b0;
      mul_sl    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        if (!is_mul) begin
          if (wr_en) regs[cw_da] <= alu_result;
          if (cw_sl) flags <= alu_flags;
          data <= alu_result;
          done <= 1'b1;
        end else begin
`ifdef REGALU_MUL_EN
          state     <= ST_MUL;
          mul_cnt   <= '0;
          mul_acc   <= '0;
          mul_a     <= op_a;
          mul_b     <= mul_b_src;
          mul_da    <= cw_da;
          mul_reg_w <= cw_reg_w;
          mul_sl    <= cw_sl;
`else
          done <= 1'b1;
`endif
        end
      end
`ifdef REGALU_MUL_EN
      if (state == ST_MUL) begin
        mul_acc <= mul_next;
        mul_a   <= mul_a << 1;
        mul_b   <= mul_b >> 1;
        mul_cnt <= mul_cnt + CNT_W'(1);
        if (mul_last) begin
          state <= ST_IDLE;
          data  <= mul_next;
          done  <= 1'b1;
          if (mul_reg_w && (mul_da != ZERO_REG)) regs[mul_da] <= mul_next;
          if (mul_sl) flags <= {2'b00, mul_next[WIDTH-1], (mul_next == '0)};
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_regfile_alu_seq.sv
// tb_regfile_alu_seq: directed and random control words against an arithmetic
// reference model; a monitor pops expected {data, status} on every done pulse.
module tb_regfile_alu_seq;

  localparam int WIDTH = 64;
  localparam int NREG  = 32;
  localparam int AW    = 5;
  localparam int CW    = 3 * AW + 8;

  logic             clock = 1'b0;
  logic             reset;
  logic             cw_valid;
  logic             cw_ready;
  logic [CW-1:0]    control_word;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] data;
  logic [4:0]       status;
  logic             busy;
  logic             done;

  regfile_alu_seq #(
    .WIDTH (WIDTH),
    .NREG  (NREG)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .cw_valid     (cw_valid),
    .cw_ready     (cw_ready),
    .control_word (control_word),
    .k            (k),
    .data         (data),
    .status       (status),
    .busy         (busy),
    .done         (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] d;
    logic [4:0]  s;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  logic [63:0] m_rf [NREG];
  logic [63:0] m_data;
  logic [3:0]  m_flags;
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] mk(input int da, input int sa, input int sb,
                                       input logic [4:0] fs, input logic rw,
                                       input logic sk, input logic sl);
    return {5'(da), 5'(sa), 5'(sb), fs, rw, sk, sl};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) m_rf[i] = '0;
    m_data  = '0;
    m_flags = '0;
  endtask

  // Reference: plain arithmetic on the architectural registers.
  task automatic model_apply(input logic [CW-1:0] cw, input logic [63:0] kv);
    logic [4:0]   da, sa, sb, fs;
    logic         rw, sk, sl, c, v, has;
    logic [63:0]  a, b, r;
    logic [64:0]  wide;
    logic [65:0]  sx;
    logic [127:0] prod;
    da = cw[22:18]; sa = cw[17:13]; sb = cw[12:8]; fs = cw[7:3];
    rw = cw[2]; sk = cw[1]; sl = cw[0];
    a = m_rf[sa];
    b = sk ? kv : m_rf[sb];
    if (fs[1]) b = ~b;
    c = 1'b0; v = 1'b0; has = 1'b1; r = '0;
    case (fs[4:2])
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: begin
        wide = {1'b0, a} + {1'b0, b} + {64'd0, fs[0]};
        r    = wide[63:0];
        c    = wide[64];
        sx   = {{2{a[63]}}, a} + {{2{b[63]}}, b} + {65'd0, fs[0]};
        v    = !((sx[65] == sx[64]) && (sx[64] == sx[63]));
      end
      3'd3: r = a ^ b;
      3'd4: r = a << b[5:0];
      3'd5: r = a >> b[5:0];
      3'd6: begin
`ifdef REGALU_MUL_EN
        prod = {64'd0, a} * {64'd0, b};
        r    = prod[63:0];
`else
        has  = 1'b0;
`endif
      end
      default: r = b;
    endcase
    if (has) begin
      m_data = r;
      if (rw && (da != 5'd31)) m_rf[da] = r;
      if (sl) m_flags = {v, c, r[63], (r == 64'd0)};
    end
    sb_q.push_back('{d: m_data, s: {(m_data == 64'd0), m_flags}});
  endtask

  // Present a word and hold it until accepted; returns cycles spent waiting.
  task automatic issue(input logic [CW-1:0] cw, input logic [63:0] kv, output int waits);
    waits = 0;
    @(negedge clock);
    cw_valid     = 1'b1;
    control_word = cw;
    k            = kv;
    while (!cw_ready && waits < 200) begin
      @(negedge clock);
      waits++;
    end
    if (!cw_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got cw_ready=0 expected 1 within 200 cycles at %0t", $time);
    end else begin
      model_apply(cw, kv);
    end
    @(posedge clock);
  endtask

  task automatic reset_and_check(input string tag);
    cw_valid = 1'b0;
    reset    = 1'b1;
    model_reset();
    sb_q.delete();
    #1;
    check({tag, "_busy"},     64'(busy),     64'(0));
    check({tag, "_ready"},    64'(cw_ready), 64'(1));
    check({tag, "_done"},     64'(done),     64'(0));
    check({tag, "_data"},     data,          64'd0);
    check({tag, "_status"},   64'(status),   64'(5'b10000));
    @(negedge clock);
    reset = 1'b0;
  endtask

  always @(negedge clock) begin
    if (!reset && done) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected_done: got done=1 expected no pending op at %0t", $time);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_data",   data,          mon_e.d);
        check("sb_status", 64'(status),   64'(mon_e.s));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int          w;
    logic [4:0]  fs;
    logic [63:0] kv;
    reset        = 1'b1;
    cw_valid     = 1'b0;
    control_word = '0;
    k            = '0;
    model_reset();
    repeat (2) @(negedge clock);
    reset_and_check("rst0");

    issue(mk(5, 31, 0, 5'b01000, 1, 1, 0), 64'd24, w);
    #1 check("b2b_done0", 64'(done), 64'(1));
    issue(mk(7, 31, 0, 5'b01000, 1, 1, 0), 64'd39, w);
    #1 check("b2b_done1", 64'(done), 64'(1));
    issue(mk(1, 5, 7, 5'b01000, 1, 0, 0), 64'd0, w);
    #1 check("b2b_done2", 64'(done), 64'(1));
    issue(mk(30, 1, 5, 5'b01100, 1, 0, 0), 64'd0, w);
    #1 check("b2b_done3", 64'(done), 64'(1));
    issue(mk(17, 30, 0, 5'b10000, 1, 1, 0), 64'd2, w);
    #1 check("b2b_done4", 64'(done), 64'(1));

    issue(mk(3, 5, 7, 5'b01011, 1, 0, 1), 64'd0, w);
    issue(mk(5, 7, 7, 5'b01011, 0, 0, 1), 64'd0, w);
    issue(mk(0, 0, 5, 5'b11100, 0, 0, 0), 64'd0, w);
    issue(mk(31, 31, 0, 5'b01001, 1, 1, 1), 64'h7FFF_FFFF_FFFF_FFFF, w);
    issue(mk(0, 0, 31, 5'b11100, 0, 0, 0), 64'd0, w);

`ifdef REGALU_MUL_EN
    issue(mk(2, 5, 7, 5'b11000, 1, 0, 0), 64'd0, w);
    #1 check("mul_busy", 64'(busy), 64'(1));
    check("mul_not_ready", 64'(cw_ready), 64'(0));
    issue(mk(0, 0, 2, 5'b11100, 0, 0, 0), 64'd0, w);
    check("mul_wait_cycles", 64'(w), 64'(64));
    issue(mk(2, 5, 7, 5'b11000, 1, 0, 1), 64'd0, w);
    @(negedge clock);
    cw_valid = 1'b0;
    repeat (10) @(posedge clock);
    #2;
    reset_and_check("rst_mul");
`else
    issue(mk(2, 31, 0, 5'b01000, 1, 1, 0), 64'd77, w);
    issue(mk(2, 5, 7, 5'b11000, 1, 0, 1), 64'd0, w);
    #1 check("nomul_done", 64'(done), 64'(1));
    check("nomul_busy", 64'(busy), 64'(0));
    issue(mk(0, 0, 2, 5'b11100, 0, 0, 0), 64'd0, w);
    check("nomul_no_wait", 64'(w), 64'(0));
    @(negedge clock);
    cw_valid = 1'b0;
    #2;
    reset_and_check("rst_mid");
`endif
    for (int i = 0; i < NREG; i++) issue(mk(0, 0, i, 5'b11100, 0, 0, 1), 64'd0, w);

    for (int n = 0; n < 150; n++) begin
      fs = 5'($urandom_range(0, 31));
`ifdef REGALU_MUL_EN
      if (fs[4:2] == 3'd6 && $urandom_range(0, 3) != 0) fs[4:2] = 3'd7;
`endif
      case ($urandom_range(0, 4))
        0:       kv = {$urandom, $urandom};
        1:       kv = 64'($urandom_range(0, 70));
        2:       kv = '1;
        3:       kv = 64'h7FFF_FFFF_FFFF_FFFF;
        default: kv = 64'h8000_0000_0000_0000;
      endcase
      issue(mk($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31), fs,
               1'($urandom), 1'($urandom), 1'($urandom)), kv, w);
    end
    @(negedge clock);
    cw_valid = 1'b0;

    for (int i = 0; i < 300 && sb_q.size() != 0; i++) @(negedge clock);
    @(negedge clock);
    check("sb_drain", 64'(sb_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
